// File: rtl/ps2_host_tx.sv
// ps2_host_tx: queued PS/2 host-to-device transmitter with request-to-send inhibit,
// deglitched clock, device-ACK check and watchdog.
module ps2_host_tx #(
    parameter int FIFO_DEPTH     = 4,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2_c_in,
    input  logic       ps2_d_in,
    output logic       ps2_c_out,
    output logic       ps2_d_out,
    output logic       tx_idle,
    output logic       tx_done,
    output logic       tx_err,
    output logic       fifo_full,
    output logic       fifo_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RTS, SEND, ACK, WAIT} state_t;

    state_t                r_state, w_next;
    logic [7:0]            r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [AW:0]           r_count;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_fclk;
    logic [IW-1:0]         r_inh;
    logic [TW-1:0]         r_wdog;
    logic [3:0]            r_n;
    logic [9:0]            r_frame;
    logic                  r_dout, r_done, r_err;
    logic                  w_fclk, w_fall, w_pop, w_push, w_inh_last, w_timeout, w_ok;
    logic [7:0]            w_head;

    assign fifo_full  = r_count == (AW+1)'(FIFO_DEPTH);
    assign fifo_empty = r_count == '0;
    assign w_pop      = r_state == IDLE && !fifo_empty;
    assign w_push     = wr_ps2 && (!fifo_full || w_pop);
    assign w_head     = r_mem[r_rptr];
    assign w_fclk     = &r_filt ? 1'b1 : ~|r_filt ? 1'b0 : r_fclk;
    assign w_fall     = r_fclk && !w_fclk;
    assign w_inh_last = r_inh == IW'(INHIBIT_CYCLES - 1);
    assign w_timeout  = r_wdog == TW'(TIMEOUT_CYCLES - 1);
    assign w_ok       = r_state == WAIT && r_fclk && ps2_d_in;
    assign tx_done    = r_done;
    assign tx_err     = r_err;

    // Queue storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wptr] <= din;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_filt  <= '1;
            r_fclk  <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_filt  <= {r_filt[FILTER_LEN-2:0], ps2_c_in};
            r_fclk  <= w_fclk;
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= IDLE;
        else r_state <= w_next;

    // Normal frame progress takes priority over the watchdog in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!fifo_empty) w_next = RTS;
            RTS:     if (w_inh_last) w_next = SEND;
            SEND:    if (w_fall && r_n == 4'd9) w_next = ACK;
                     else if (w_timeout) w_next = IDLE;
            ACK:     if (w_fall) w_next = ps2_d_in ? IDLE : WAIT;
                     else if (w_timeout) w_next = IDLE;
            WAIT:    if (w_ok || w_timeout) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_inh   <= '0;
            r_wdog  <= '0;
            r_n     <= '0;
            r_frame <= '1;
            r_dout  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_inh  <= r_state == RTS ? r_inh + IW'(1) : '0;
            r_wdog <= r_state inside {SEND, ACK, WAIT} ? r_wdog + TW'(1) : '0;
            r_done <= w_ok;
            r_err  <= r_state inside {SEND, ACK, WAIT} && w_next == IDLE && !w_ok;
            if (w_pop) begin
                r_frame <= {1'b1, ~^w_head, w_head};
                r_n     <= '0;
            end
            if (r_state == RTS && w_inh_last) r_dout <= 1'b0;
            else if (r_state == SEND && w_fall) begin
                r_dout  <= r_frame[0];
                r_frame <= {1'b1, r_frame[9:1]};
                r_n     <= r_n + 4'd1;
            end
        end

    // Data is pulled low on the final inhibit cycle to signal the start bit.
    always_comb begin
        ps2_c_out = r_state != RTS;
        ps2_d_out = r_state == RTS ? !w_inh_last : r_state == SEND ? r_dout : 1'b1;
        tx_idle   = r_state == IDLE;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed frames against an open-drain device model for ps2_host_tx.
module tb_ps2_host_tx;
    localparam int FL  = 4;
    localparam int INH = 50;
    localparam int TO  = 3000;
    localparam int H   = 40;

    logic       clk, reset, wr_ps2, dev_clk, dev_data;
    logic [7:0] din;
    logic       ps2_c_in, ps2_d_in, ps2_c_out, ps2_d_out;
    logic       tx_idle, tx_done, tx_err, fifo_full, fifo_empty;
    int         n_cmp = 0, n_bad = 0, n_done = 0, n_err = 0;

    assign ps2_c_in = ps2_c_out & dev_clk;
    assign ps2_d_in = ps2_d_out & dev_data;

    ps2_host_tx #(.FIFO_DEPTH(4), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
        .ps2_c_in(ps2_c_in), .ps2_d_in(ps2_d_in), .ps2_c_out(ps2_c_out), .ps2_d_out(ps2_d_out),
        .tx_idle(tx_idle), .tx_done(tx_done), .tx_err(tx_err),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) n_done++;
        if (tx_err) n_err++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  din;
        logic        ack;
        int          glitch;
        logic [10:0] bits;
        logic        done;
    } vec_t;

    vec_t tv[7];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        din = b;
        wr_ps2 = 1'b1;
        step();
        wr_ps2 = 1'b0;
    endtask

    // Device side: bits[0] is sampled at clock release, bits[1..10] on each rising edge.
    task automatic run_frame(input logic ack, input int glitch, input int abort_at,
                             output logic [10:0] bits, output int low);
        int   cyc;
        logic last_d;
        bits = '0;
        low = 0;
        cyc = 0;
        last_d = 1'b1;
        while (ps2_c_out && cyc < 2000) begin step(); cyc++; end
        chk("rts_start", cyc < 2000, 1);
        while (!ps2_c_out && low < 2000) begin last_d = ps2_d_out; step(); low++; end
        chk("rts_data_low_last", last_d, 0);
        bits[0] = ps2_d_in;
        wait_n(H);
        for (int i = 1; i <= 10; i++) begin
            dev_clk = 1'b0;
            if (i == abort_at) begin
                wait_n(H / 2);
                return;
            end
            wait_n(H);
            dev_clk = 1'b1;
            bits[i] = ps2_d_in;
            if (i == glitch) begin
                wait_n(H / 2);
                dev_clk = 1'b0;
                wait_n(FL - 1);
                dev_clk = 1'b1;
                wait_n(H / 2 - FL + 1);
            end else wait_n(H);
        end
        dev_data = !ack;
        dev_clk = 1'b0;
        wait_n(H);
        dev_clk = 1'b1;
        wait_n(H);
        dev_data = 1'b1;
    endtask

    initial begin
        logic [10:0] bits;
        int          low, cyc, d0, e0;
        tv[0] = '{8'hA3, 1'b1, 0, 11'b1_1_10100011_0, 1'b1};
        tv[1] = '{8'h00, 1'b0, 0, 11'b1_1_00000000_0, 1'b0};
        tv[2] = '{8'h6B, 1'b1, 5, 11'b1_0_01101011_0, 1'b1};
        tv[3] = '{8'hFF, 1'b1, 0, 11'b1_1_11111111_0, 1'b1};
        tv[4] = '{8'hF4, 1'b1, 0, 11'b1_0_11110100_0, 1'b1};
        tv[5] = '{8'hF3, 1'b1, 0, 11'b1_1_11110011_0, 1'b1};
        tv[6] = '{8'hC8, 1'b1, 0, 11'b1_0_11001000_0, 1'b1};
        reset = 1'b0;
        wr_ps2 = 1'b0;
        din = 8'h00;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        wait_n(3);
        chk("rst_c_out", ps2_c_out, 1);
        chk("rst_d_out", ps2_d_out, 1);
        chk("rst_idle", tx_idle, 1);
        chk("rst_done", tx_done, 0);
        chk("rst_err", tx_err, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_empty", fifo_empty, 1);
        reset = 1'b1;
        wait_n(2);

        for (int v = 0; v < 3; v++) begin
            d0 = n_done;
            e0 = n_err;
            push(tv[v].din);
            chk($sformatf("not_empty[%0d]", v), fifo_empty, 0);
            chk($sformatf("c_high_after_wr[%0d]", v), ps2_c_out, 1);
            run_frame(tv[v].ack, tv[v].glitch, 0, bits, low);
            wait_n(4);
            chk($sformatf("inhibit_len[%0d]", v), low, INH);
            chk($sformatf("frame_bits[%0d]", v), bits, tv[v].bits);
            chk($sformatf("done_cnt[%0d]", v), n_done - d0, tv[v].done);
            chk($sformatf("err_cnt[%0d]", v), n_err - e0, !tv[v].done);
            chk($sformatf("idle_after[%0d]", v), tx_idle, 1);
        end

        // Stalled frame holds the FSM while the burst fills the queue, then times out.
        d0 = n_done;
        e0 = n_err;
        push(8'h00);
        push(8'hFF);
        push(8'hF4);
        push(8'hF3);
        push(8'hC8);
        chk("full_after_4th", fifo_full, 1);
        push(8'h11);
        chk("full_after_drop", fifo_full, 1);
        cyc = 0;
        while (!ps2_c_out && cyc < 200) begin step(); cyc++; end
        chk("stall_start_bit", ps2_d_out, 0);
        cyc = 0;
        while (!tx_err && cyc < TO + 100) begin step(); cyc++; end
        chk("timeout_cycles", cyc, TO);
        chk("timeout_c_rel", ps2_c_out, 1);
        chk("timeout_d_rel", ps2_d_out, 1);
        for (int v = 3; v < 7; v++) begin
            run_frame(1'b1, 0, 0, bits, low);
            chk($sformatf("burst_bits[%0d]", v), bits, tv[v].bits);
            chk($sformatf("burst_inhibit[%0d]", v), low, INH);
        end
        wait_n(4);
        chk("burst_done_cnt", n_done - d0, 4);
        chk("burst_err_cnt", n_err - e0, 1);
        chk("burst_empty", fifo_empty, 1);
        wait_n(200);
        chk("dropped_not_sent", tx_idle, 1);
        chk("dropped_no_done", n_done - d0, 4);

        // Reset mid-frame: lines release asynchronously and the queued byte is lost.
        push(8'h0F);
        push(8'h22);
        run_frame(1'b1, 0, 5, bits, low);
        d0 = n_done;
        e0 = n_err;
        chk("pre_rst_d_low", ps2_d_out, 0);
        chk("pre_rst_queued", fifo_empty, 0);
        step();
        reset = 1'b0;
        #1;
        chk("async_rst_c", ps2_c_out, 1);
        chk("async_rst_d", ps2_d_out, 1);
        chk("async_rst_empty", fifo_empty, 1);
        dev_clk = 1'b1;
        wait_n(3);
        reset = 1'b1;
        wait_n(300);
        chk("post_rst_idle", tx_idle, 1);
        chk("post_rst_no_done", n_done - d0, 0);
        chk("post_rst_no_err", n_err - e0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Parametrised PS/2 host-to-device transmitter with command FIFO, programmable request-to-send inhibit, clock deglitch filter, device-ACK check and watchdog timeout. Successor to the single-byte `ps2_transmitter`: it queues several command bytes and sends them back-to-back without babysitting. It reports a failed or unacknowledged frame instead of hanging. It sits between the mouse/keyboard command logic and the open-drain PS/2 pad drivers.

## Interface
- `FIFO_DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `INHIBIT_CYCLES`, default 5000: clk cycles clock is held low for request-to-send (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: max cycles from clock release to ACK (15 ms at 50 MHz).
- `FILTER_LEN`, default 8: ps2_c_in deglitch shift length, ≥2.
- `clk`, in, 1: system clock; all state on rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `wr_ps2`, in, 1: push `din` into FIFO this cycle.
- `din`, in, 8: command byte.
- `ps2_c_in`, in, 1: PS/2 clock pad input.
- `ps2_d_in`, in, 1: PS/2 data pad input.
- `ps2_c_out`, out, 1: 0 = pull clock low, 1 = release.
- `ps2_d_out`, out, 1: 0 = pull data low, 1 = release.
- `tx_idle`, out, 1: FSM in IDLE.
- `tx_done`, out, 1: one-cycle pulse, frame ACKed.
- `tx_err`, out, 1: one-cycle pulse, frame failed (no ACK or timeout).
- `fifo_full`, out, 1: FIFO holds FIFO_DEPTH bytes.
- `fifo_empty`, out, 1: FIFO holds 0 bytes.

## Operation
- Reset (reset=0): FIFO cleared, FSM IDLE, filter loaded all-ones. Outputs: ps2_c_out=1, ps2_d_out=1, tx_idle=1, tx_done=0, tx_err=0, fifo_full=0, fifo_empty=1. Reset asserted mid-frame releases both lines immediately (asynchronously) and discards the queue.
- FIFO: write when wr_ps2=1 and not full; write while full is dropped silently. A pop occurs on the IDLE→RTS transition. A simultaneous write and pop when full is accepted. Pointers wrap modulo FIFO_DEPTH.
- Filter: ps2_c_in is shifted into a FILTER_LEN register. Filtered clock goes 1 when all bits are 1 and 0 when all are 0; otherwise it holds. fall = filtered 1→0.
- Frame: 11 bits. Bit 0 is the start bit (0). Bits 1–8 are data, LSB first. Bit 9 is odd parity (~^byte). Bit 10 is the stop bit (data released). The device ACK is expected at the 11th fall.
- FSM:
  - IDLE: when fifo_empty=0, pop the byte into the shift register and go to RTS.
  - RTS: ps2_c_out=0 for INHIBIT_CYCLES cycles. On the last cycle, set ps2_d_out=0 and go to SEND with ps2_c_out=1.
  - SEND: bit counter n starts at 0. On each fall, n increments. For n=1..8, ps2_d_out=data[n-1]; for n=9, parity; for n=10, ps2_d_out=1. Go to ACK.
  - ACK: on the next fall, sample ps2_d_in. If it is 0, go to WAIT; if 1, pulse tx_err and go to IDLE.
  - WAIT: wait until filtered clock=1 and ps2_d_in=1, then pulse tx_done and go to IDLE.
- Watchdog: counter cleared on RTS→SEND and running in SEND/ACK/WAIT. When it reaches TIMEOUT_CYCLES: release both lines, pulse tx_err, go to IDLE. Timeout and ACK in the same cycle: ACK wins.
- After tx_done or tx_err, the next FIFO byte starts automatically (IDLE lasts 1 cycle).
- Device-to-host activity on the lines during IDLE is ignored; RTS overrides it (host inhibit).

## Timing
- wr_ps2 at edge k: fifo_empty=0 after edge k. If FSM idle: IDLE→RTS at edge k+1 and ps2_c_out=0 from edge k+1.
- ps2_c_out low for exactly INHIBIT_CYCLES cycles. ps2_d_out goes low one cycle before ps2_c_out returns to 1.
- Fall detect latency: FILTER_LEN+1 clk cycles after the pad edge. The data update follows the detected fall by ≤1 cycle, always while the pad clock is low.
- tx_done/tx_err are registered and last one cycle. tx_idle=0 from RTS entry until the cycle after the pulse.

## Test plan
- din=0xA3 with a device model clocking at 10 kHz and ACKing: ps2_c_out low 5000 cycles; data bits sampled on rising edges are 0,1,1,0,0,0,1,0,1, parity 1, stop 1; tx_done pulses once; tx_idle returns to 1.
- Burst-write 0xFF, 0xF4, 0xF3, 0xC8, then 0x11 while full: 0x11 dropped; fifo_full=1 after the 4th write; four frames sent in order; parity bits 1,0,1,0; four tx_done pulses; fifo_empty=1 at the end.
- Device never clocks after RTS: tx_err at exactly TIMEOUT_CYCLES after clock release; lines released; next queued byte starts.
- Device leaves data high at the 11th fall (no ACK): tx_err pulses once, tx_done stays 0.
- Glitch of FILTER_LEN-1 cycles low on ps2_c_in during SEND: bit counter unchanged and frame completes correctly.
- reset=0 asserted at bit 5 of a frame: ps2_c_out=ps2_d_out=1 in the same cycle, fifo_empty=1; after release, tx_idle=1 and no tx_done/tx_err pulse occurs.
